// File: rtl/sync_filter_pkg.sv
// Shared constants and helpers for the sync_filter slice: legal parameter
// bounds and the per-channel stability counter width.
package sync_filter_pkg;

  localparam int MIN_WIDTH         = 1;
  localparam int MIN_STAGES        = 2;
  localparam int MIN_FILTER_CYCLES = 0;

  // A filter of N cycles counts 0..N-1; width 1 keeps the bypass case well-formed.
  function automatic int cnt_width(input int filter_cycles);
    if (filter_cycles < 1) begin
      return 1;
    end
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// One channel: STAGES-deep synchronizer, optional stability filter, and
// edge pulses derived from the filtered level.
module sync_filter_channel
  import sync_filter_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 0,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic signal_in,
  output logic signal_out,
  output logic rise,
  output logic fall
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_ff;
  logic sync;
  logic out_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_ff <= {STAGES{RESET_VALUE}};
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], signal_in};
    end
  end

  assign sync = sync_ff[STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign signal_out = sync;
    end else begin : g_filter
      localparam int            CW       = cnt_width(FILTER_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          filt;

      // Any cycle of agreement restarts the count, so only an unbroken run
      // of FILTER_CYCLES mismatching cycles moves the output.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          cnt  <= '0;
          filt <= RESET_VALUE;
        end else if (sync == filt) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt  <= '0;
          filt <= sync;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign signal_out = filt;
    end
  endgenerate

  // Delayed copy resets to the same value as the output, so reset release
  // never looks like an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_d <= RESET_VALUE;
    end else begin
      out_d <= signal_out;
    end
  end

  assign rise = signal_out & ~out_d;
  assign fall = ~signal_out & out_d;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel synchronizer/debouncer: parameter checks plus one
// independent sync_filter_channel per input bit.
module sync_filter
  import sync_filter_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] signal_in,
  output logic [WIDTH-1:0] signal_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  generate
    if (WIDTH < MIN_WIDTH) begin : g_bad_width
      $error("sync_filter: WIDTH must be at least 1");
    end
    if (STAGES < MIN_STAGES) begin : g_bad_stages
      $error("sync_filter: STAGES must be at least 2");
    end
    if (FILTER_CYCLES < MIN_FILTER_CYCLES) begin : g_bad_filter
      $error("sync_filter: FILTER_CYCLES must not be negative");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      sync_filter_channel #(
        .STAGES        (STAGES),
        .FILTER_CYCLES (FILTER_CYCLES),
        .RESET_VALUE   (RESET_VALUE[i])
      ) u_channel (
        .clk        (clk),
        .resetn     (resetn),
        .signal_in  (signal_in[i]),
        .signal_out (signal_out[i]),
        .rise       (rise[i]),
        .fall       (fall[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: bypass, filtered and multi-channel
// instances sharing one clock and reset.
module tb_sync_filter;

  logic clk = 1'b0;
  logic resetn;

  logic       byp_in, byp_out, byp_rise, byp_fall;
  logic       filt_in, filt_out, filt_rise, filt_fall;
  logic [3:0] wide_in, wide_out, wide_rise, wide_fall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(0), .RESET_VALUE(1'b0)) u_byp (
    .clk(clk), .resetn(resetn), .signal_in(byp_in),
    .signal_out(byp_out), .rise(byp_rise), .fall(byp_fall));

  sync_filter #(.WIDTH(1), .STAGES(3), .FILTER_CYCLES(4), .RESET_VALUE(1'b0)) u_filt (
    .clk(clk), .resetn(resetn), .signal_in(filt_in),
    .signal_out(filt_out), .rise(filt_rise), .fall(filt_fall));

  sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(2), .RESET_VALUE(4'b1010)) u_wide (
    .clk(clk), .resetn(resetn), .signal_in(wide_in),
    .signal_out(wide_out), .rise(wide_rise), .fall(wide_fall));

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    byp_in  = 1'b1;
    filt_in = 1'b1;
    wide_in = 4'b0101;
    step(3);
    checks++; if (byp_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_byp_out got=%b exp=0", byp_out); end
    checks++; if ({byp_rise, byp_fall} !== 2'b00) begin failures++; $display("[TB] FAIL reset_byp_edges got=%b exp=00", {byp_rise, byp_fall}); end
    checks++; if (filt_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_filt_out got=%b exp=0", filt_out); end
    checks++; if (wide_out !== 4'b1010) begin failures++; $display("[TB] FAIL reset_wide_out got=%b exp=1010", wide_out); end
    checks++; if ({wide_rise, wide_fall} !== 8'h00) begin failures++; $display("[TB] FAIL reset_wide_edges got=%b exp=00000000", {wide_rise, wide_fall}); end
    byp_in  = 1'b0;
    filt_in = 1'b0;
    wide_in = 4'b1010;
    resetn  = 1'b1;
    step(10);
    checks++; if ({byp_out, filt_out} !== 2'b00) begin failures++; $display("[TB] FAIL reset_settled got=%b exp=00", {byp_out, filt_out}); end
  endtask

  task automatic test_bypass();
    byp_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checks++; if (byp_out !== (k >= 2)) begin failures++; $display("[TB] FAIL byp_rise_out k=%0d got=%b exp=%b", k, byp_out, (k >= 2)); end
      checks++; if ({byp_rise, byp_fall} !== {(k == 2), 1'b0}) begin failures++; $display("[TB] FAIL byp_rise_pulse k=%0d got=%b exp=%b", k, {byp_rise, byp_fall}, {(k == 2), 1'b0}); end
    end
    byp_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checks++; if (byp_out !== (k < 2)) begin failures++; $display("[TB] FAIL byp_fall_out k=%0d got=%b exp=%b", k, byp_out, (k < 2)); end
      checks++; if ({byp_rise, byp_fall} !== {1'b0, (k == 2)}) begin failures++; $display("[TB] FAIL byp_fall_pulse k=%0d got=%b exp=%b", k, {byp_rise, byp_fall}, {1'b0, (k == 2)}); end
    end
  endtask

  task automatic test_filter_latency();
    filt_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      checks++; if (filt_out !== (k >= 7)) begin failures++; $display("[TB] FAIL filt_rise_out k=%0d got=%b exp=%b", k, filt_out, (k >= 7)); end
      checks++; if ({filt_rise, filt_fall} !== {(k == 7), 1'b0}) begin failures++; $display("[TB] FAIL filt_rise_pulse k=%0d got=%b exp=%b", k, {filt_rise, filt_fall}, {(k == 7), 1'b0}); end
    end
    filt_in = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      checks++; if (filt_out !== (k < 7)) begin failures++; $display("[TB] FAIL filt_fall_out k=%0d got=%b exp=%b", k, filt_out, (k < 7)); end
      checks++; if ({filt_rise, filt_fall} !== {1'b0, (k == 7)}) begin failures++; $display("[TB] FAIL filt_fall_pulse k=%0d got=%b exp=%b", k, {filt_rise, filt_fall}, {1'b0, (k == 7)}); end
    end
  endtask

  task automatic test_glitch();
    filt_in = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      checks++; if ({filt_out, filt_rise, filt_fall} !== 3'b000) begin failures++; $display("[TB] FAIL glitch k=%0d got=%b exp=000", k, {filt_out, filt_rise, filt_fall}); end
      if (k == 3) filt_in = 1'b0;
    end
  endtask

  task automatic test_restart();
    logic [7:0] pat;
    pat = 8'b1111_0111;
    filt_in = pat[0];
    for (int k = 1; k <= 14; k++) begin
      step(1);
      checks++; if (filt_out !== (k >= 11)) begin failures++; $display("[TB] FAIL restart_out k=%0d got=%b exp=%b", k, filt_out, (k >= 11)); end
      checks++; if ({filt_rise, filt_fall} !== {(k == 11), 1'b0}) begin failures++; $display("[TB] FAIL restart_pulse k=%0d got=%b exp=%b", k, {filt_rise, filt_fall}, {(k == 11), 1'b0}); end
      filt_in = (k < 8) ? pat[k] : 1'b1;
    end
  endtask

  task automatic test_reset_mid_count();
    filt_in = 1'b0;
    step(5);
    checks++; if (filt_out !== 1'b1) begin failures++; $display("[TB] FAIL midcount_pre got=%b exp=1", filt_out); end
    #1 resetn = 1'b0;
    #1;
    checks++; if ({filt_out, filt_rise, filt_fall} !== 3'b000) begin failures++; $display("[TB] FAIL midcount_async got=%b exp=000", {filt_out, filt_rise, filt_fall}); end
    filt_in = 1'b1;
    step(2);
    checks++; if (filt_out !== 1'b0) begin failures++; $display("[TB] FAIL midcount_held got=%b exp=0", filt_out); end
    resetn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      checks++; if (filt_out !== (k >= 7)) begin failures++; $display("[TB] FAIL midcount_out k=%0d got=%b exp=%b", k, filt_out, (k >= 7)); end
      checks++; if ({filt_rise, filt_fall} !== {(k == 7), 1'b0}) begin failures++; $display("[TB] FAIL midcount_pulse k=%0d got=%b exp=%b", k, {filt_rise, filt_fall}, {(k == 7), 1'b0}); end
    end
  endtask

  task automatic test_wide_channels();
    logic [3:0] exp_out, exp_rise, exp_fall;
    wide_in = 4'b1010;
    resetn  = 1'b0;
    step(2);
    checks++; if (wide_out !== 4'b1010) begin failures++; $display("[TB] FAIL wide_reset got=%b exp=1010", wide_out); end
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      checks++; if ({wide_out, wide_rise, wide_fall} !== 12'b1010_0000_0000) begin failures++; $display("[TB] FAIL wide_release k=%0d got=%b exp=101000000000", k, {wide_out, wide_rise, wide_fall}); end
    end
    wide_in = 4'b1011;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      exp_out  = (k >= 4) ? 4'b1011 : 4'b1010;
      exp_rise = (k == 4) ? 4'b0001 : 4'b0000;
      checks++; if ({wide_out, wide_rise, wide_fall} !== {exp_out, exp_rise, 4'b0000}) begin failures++; $display("[TB] FAIL wide_rise k=%0d got=%b exp=%b", k, {wide_out, wide_rise, wide_fall}, {exp_out, exp_rise, 4'b0000}); end
    end
    wide_in = 4'b1010;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      exp_out  = (k >= 4) ? 4'b1010 : 4'b1011;
      exp_fall = (k == 4) ? 4'b0001 : 4'b0000;
      checks++; if ({wide_out, wide_rise, wide_fall} !== {exp_out, 4'b0000, exp_fall}) begin failures++; $display("[TB] FAIL wide_fall k=%0d got=%b exp=%b", k, {wide_out, wide_rise, wide_fall}, {exp_out, 4'b0000, exp_fall}); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_filter_latency();
    test_glitch();
    test_restart();
    test_reset_mid_count();
    test_wide_channels();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
